// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid never depends on ready.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [4:0]       rd_id,
  input  logic             flush,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       result_rd_id,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q, quot_q, dvsr_q;
  logic             neg_q, neg_r, rem_sel;

  logic             accept, is_signed, div_zero, sgn_ovf, special;
  logic [WIDTH-1:0] abs_a, abs_b, special_res;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] rem_nx, quot_nx, final_res;

  assign start_ready = rst_n && (state == IDLE);
  assign busy        = (state != IDLE);
  assign accept      = start_valid && start_ready && !flush;

  assign is_signed = !op[0];
  assign div_zero  = (divisor == '0);
  assign sgn_ovf   = is_signed && (dividend == INT_MIN) && (divisor == ALL_ONES);
  assign special   = div_zero || sgn_ovf;
  // |INT_MIN| wraps to INT_MIN, which is exactly 2^(WIDTH-1) read as unsigned.
  assign abs_a = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign abs_b = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = op[1] ? dividend : ALL_ONES;
    else if (sgn_ovf)
      special_res = op[1] ? '0 : INT_MIN;
  end

  // One restoring step: the partial remainder stays below the divisor, so WIDTH+1 bits suffice.
  assign shifted = {rem_q, quot_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvsr_q};
  assign rem_nx  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quot_nx = {quot_q[WIDTH-2:0], ~diff[WIDTH]};
  assign final_res = rem_sel ? (neg_r ? -rem_nx : rem_nx)
                             : (neg_q ? -quot_nx : quot_nx);

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (start_valid) state_d = special ? DONE : CALC;
      CALC: if (cnt == LAST_CNT) state_d = DONE;
      DONE: if (result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      result_valid <= 1'b0;
    end else begin
      state        <= state_d;
      result_valid <= (state_d == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      rem_q        <= '0;
      quot_q       <= '0;
      dvsr_q       <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      rem_sel      <= 1'b0;
      result       <= '0;
      result_rd_id <= '0;
    end else if (accept) begin
      rem_sel      <= op[1];
      result_rd_id <= rd_id;
      if (special) begin
        result <= special_res;
      end else begin
        dvsr_q <= abs_b;
        quot_q <= abs_a;
        rem_q  <= '0;
        cnt    <= '0;
        neg_q  <= is_signed && (dividend[WIDTH-1] != divisor[WIDTH-1]);
        neg_r  <= is_signed && dividend[WIDTH-1];
      end
    end else if (state == CALC && !flush) begin
      rem_q  <= rem_nx;
      quot_q <= quot_nx;
      cnt    <= cnt + 1'b1;
      if (cnt == LAST_CNT) result <= final_res;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed vector table, randomized ops against an arithmetic model,
// and hand-written backpressure, flush and reset sequences.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [1:0]  op;
  logic [31:0] dividend, divisor;
  logic [4:0]  rd_id;
  logic        flush;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result;
  logic [4:0]  result_rd_id;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .dividend(dividend), .divisor(divisor), .rd_id(rd_id), .flush(flush),
    .result_valid(result_valid), .result_ready(result_ready), .result(result),
    .result_rd_id(result_rd_id), .busy(busy)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: plain RV32M arithmetic rules.
  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    if (!o[0]) begin
      if (o[1]) return sa % sb;
      return sa / sb;
    end
    if (o[1]) return a % b;
    return a / b;
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Driver: waits for result_valid from the accept edge; lat is the cycle it first shows.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!result_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!result_valid) chk("result_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res,
                        output logic [4:0] rdo, output int lat);
    chk("start_ready_before", {31'd0, start_ready}, 32'd1);
    op = o; dividend = a; divisor = b; rd_id = rd; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    wait_result(lat);
    res = result;
    rdo = result_rd_id;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    chk("handshake_to_idle", {30'd0, result_valid, start_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] res, a, b, exp;
    logic [4:0]  rdo;
    logic [1:0]  o;
    int          lat, lat2;
    logic        seen_valid;

    vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'h0000_000E, 33};
    vecs[1]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 33};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 33};
    vecs[3]  = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD, 33};
    vecs[4]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'h0000_0001, 33};
    vecs[5]  = '{2'b11, 32'hFFFF_FFF9,  32'd2,          32'h0000_0001, 33};
    vecs[6]  = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF, 1};
    vecs[7]  = '{2'b11, 32'd5,          32'd0,          32'h0000_0005, 1};
    vecs[8]  = '{2'b10, 32'hFFFF_FFFD,  32'd0,          32'hFFFF_FFFD, 1};
    vecs[9]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1};
    vecs[10] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 1};
    vecs[11] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 33};
    vecs[12] = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF, 33};
    vecs[13] = '{2'b00, 32'h8000_0000,  32'd1,          32'h8000_0000, 33};
    vecs[14] = '{2'b10, 32'h8000_0000,  32'd3,          32'hFFFF_FFFE, 33};

    rst_n = 1'b0; start_valid = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
    rd_id = '0; flush = 1'b0; result_ready = 1'b0;
    #1;
    chk("start_ready_in_reset", {31'd0, start_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_result_valid", {31'd0, result_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_rd_id", {27'd0, result_rd_id}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", {31'd0, start_ready}, 32'd1);

    // Directed vectors
    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 5), res, rdo, lat);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_rd_id", i), {27'd0, rdo}, 32'(i + 5));
    end

    // Randomized ops against the model, via the scoreboard queue
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      exp_q.push_back(ref_result(o, a, b));
      run_op(o, a, b, 5'(i), res, rdo, lat);
      exp = exp_q.pop_front();
      chk($sformatf("rand%0d_result op=%0d a=%08h b=%08h", i, o, a, b), res, exp);
      chk($sformatf("rand%0d_latency", i), lat, ref_lat(o, a, b));
    end

    // Backpressure, then a back-to-back request one cycle after the handshake
    op = 2'b01; dividend = 32'd100; divisor = 32'd7; rd_id = 5'd9; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    wait_result(lat);
    chk("bp_latency", lat, 33);
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp_hold%0d", c),
          {result_rd_id, busy, start_ready, result_valid, result[24:0]},
          {5'd9, 1'b1, 1'b0, 1'b1, 25'd14});
      @(posedge clk); #1;
    end
    result_ready = 1'b1;
    op = 2'b01; dividend = 32'd9; divisor = 32'd3; rd_id = 5'd17; start_valid = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    chk("bp_idle_after_hs", {29'd0, busy, start_ready, result_valid}, 32'b010);
    @(posedge clk); #1;
    start_valid = 1'b0;
    chk("b2b_accepted", {30'd0, busy, start_ready}, 32'b10);
    wait_result(lat);
    chk("b2b_latency", lat, 33);
    chk("b2b_result", result, 32'd3);
    chk("b2b_rd_id", {27'd0, result_rd_id}, 32'd17);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;

    // Flush at cycle 10 of CALC
    op = 2'b01; dividend = 32'hFFFF_FFFF; divisor = 32'd3; rd_id = 5'd3; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_idle", {29'd0, busy, start_ready, result_valid}, 32'b010);
    seen_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (result_valid) seen_valid = 1'b1;
    end
    chk("flush_no_result", {31'd0, seen_valid}, 32'd0);
    // flush suppresses an accept in IDLE
    op = 2'b01; dividend = 32'd9; divisor = 32'd3; rd_id = 5'd4; start_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0; flush = 1'b0;
    chk("flush_blocks_accept", {31'd0, busy}, 32'd0);
    run_op(2'b01, 32'd9, 32'd3, 5'd4, res, rdo, lat);
    chk("after_flush_result", res, 32'd3);
    chk("after_flush_latency", lat, 33);

    // Reset for one cycle mid-CALC
    op = 2'b00; dividend = 32'd1000; divisor = 32'd7; rd_id = 5'd21; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midcalc_ready_in_reset", {31'd0, start_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("midcalc_reset_outputs",
        {busy, start_ready, result_valid, result_rd_id},
        {1'b0, 1'b1, 1'b0, 5'd0});
    chk("midcalc_reset_result", result, 32'd0);
    seen_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (result_valid) seen_valid = 1'b1;
    end
    chk("reset_no_result", {31'd0, seen_valid}, 32'd0);
    run_op(2'b01, 32'd9, 32'd3, 5'd6, res, rdo, lat);
    chk("after_reset_result", res, 32'd3);
    chk("after_reset_rd_id", {27'd0, rdo}, 32'd6);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
